// File: rtl/i2s_slave_if_pkg.sv
// Shared definitions for the I2S slave interface.
// Holds the slot-tracking state encoding and the default sample/frame sizes.
// Optional feature macro used by the design: I2S_SLAVE_LJ_EN (left-justified format).
package i2s_slave_if_pkg;

  typedef logic [1:0] state_t;

  // Waiting for the first lr_clk falling edge, then left and right slots.
  localparam state_t StAlign = 2'd0;
  localparam state_t StLeft  = 2'd1;
  localparam state_t StRight = 2'd2;

  localparam int unsigned SampleWDefault  = 16;
  localparam int unsigned FrameMinDefault = 32;

endpackage

// File: rtl/i2s_slave_if_sync_edge.sv
// Two-flop synchronizer for an asynchronous single-bit input, plus single-cycle
// rise/fall pulses derived from the synchronized copy.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   d     - asynchronous input pin
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module i2s_slave_if_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_slave_if.sv
// I2S slave interface: the codec is bit-clock and LR-clock master. Captures
// serial ADC data into {left,right} words pushed to an ADC FIFO and serialises
// {left,right} words popped from a show-ahead DAC FIFO onto dacdat.
// Optional feature macro: I2S_SLAVE_LJ_EN selects left-justified format (MSB on
// the first b_clk rise of a slot); undefined gives standard I2S one-bit delay.
// Ports:
//   clk, reset          - system clock (>= 8x b_clk), async active-low reset
//   b_clk, lr_clk       - codec bit clock and LR clock (low = left), asynchronous
//   adcdat / dacdat     - serial ADC input / serial DAC output
//   dac_data_in         - {left,right} DAC word, dac_fifo_empty, dac_rd pop strobe
//   adc_data_out        - {left,right} ADC word, adc_fifo_full, adc_wr push strobe
//   underrun, overrun   - sticky error flags, cleared only by reset
module i2s_slave_if
  import i2s_slave_if_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = SampleWDefault,
  parameter int unsigned FRAME_MIN = FrameMinDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  b_clk,
  input  logic                  lr_clk,
  input  logic                  adcdat,
  output logic                  dacdat,
  input  logic [2*SAMPLE_W-1:0] dac_data_in,
  input  logic                  dac_fifo_empty,
  output logic                  dac_rd,
  output logic [2*SAMPLE_W-1:0] adc_data_out,
  input  logic                  adc_fifo_full,
  output logic                  adc_wr,
  output logic                  underrun,
  output logic                  overrun
);

`ifdef I2S_SLAVE_LJ_EN
  localparam bit LjMode = 1'b1;
`else
  localparam bit LjMode = 1'b0;
`endif

  // Slot bit index one past the last data bit.
  localparam logic [5:0] RxEnd    = 6'(SAMPLE_W) + (LjMode ? 6'd0 : 6'd1);
  localparam logic [7:0] FrameMin = 8'(FRAME_MIN);

  logic b_rise, b_fall, lr_rise, lr_fall;
  logic adc_meta_q, adc_bit_q;

  state_t              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic [SAMPLE_W-1:0] dac_r_q, dac_r_d, tx_sr_q, tx_sr_d;
  logic                dacdat_q, dacdat_d;
  logic [2*SAMPLE_W-1:0] adc_data_q, adc_data_d;
  logic                adc_wr_q, adc_wr_d;
  logic                underrun_q, underrun_d, overrun_q, overrun_d;

  logic                enter_left, enter_right, slot_start, rx_data;
  logic [4:0]          bit_idx;
  logic [SAMPLE_W-1:0] tx_word;

  i2s_slave_if_sync_edge u_sync_bclk (
    .clk   (clk),
    .reset (reset),
    .d     (b_clk),
    .rise  (b_rise),
    .fall  (b_fall)
  );

  i2s_slave_if_sync_edge u_sync_lrclk (
    .clk   (clk),
    .reset (reset),
    .d     (lr_clk),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  // adcdat has the same synchronizer depth as b_clk, so the bit seen on a
  // detected b_clk rise is the one present at the pin rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_meta_q <= 1'b0;
      adc_bit_q  <= 1'b0;
    end else begin
      adc_meta_q <= adcdat;
      adc_bit_q  <= adc_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    dac_r_d     = dac_r_q;
    tx_sr_d     = tx_sr_q;
    dacdat_d    = dacdat_q;
    adc_data_d  = adc_data_q;
    adc_wr_d    = 1'b0;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    dac_rd      = 1'b0;
    enter_left  = 1'b0;
    enter_right = 1'b0;
    tx_word     = '0;
    rx_data     = 1'b0;

    case (state_q)
      StAlign: if (lr_fall) enter_left = 1'b1;
      StLeft:  if (lr_rise) enter_right = 1'b1;
      StRight: begin
        if (lr_fall) begin
          if (frame_cnt_q >= FrameMin) begin
            enter_left = 1'b1;
            adc_data_d = {rx_l_q, rx_r_q};
            if (adc_fifo_full) overrun_d = 1'b1;
            else               adc_wr_d  = 1'b1;
          end else begin
            // Short frame: drop it silently and realign.
            state_d = StAlign;
          end
        end
      end
      default: state_d = StAlign;
    endcase

    if (enter_left) begin
      state_d     = StLeft;
      rx_l_d      = '0;
      rx_r_d      = '0;
      frame_cnt_d = '0;
      if (dac_fifo_empty) begin
        underrun_d = 1'b1;
        dac_r_d    = '0;
      end else begin
        dac_rd  = 1'b1;
        tx_word = dac_data_in[2*SAMPLE_W-1:SAMPLE_W];
        dac_r_d = dac_data_in[SAMPLE_W-1:0];
      end
    end
    if (enter_right) begin
      state_d = StRight;
      tx_word = dac_r_q;
    end

    // The lr_clk edge clears the counter before a coincident b_clk rise counts.
    slot_start = enter_left | enter_right;
    bit_idx    = slot_start ? 5'd0 : bit_cnt_q;
    bit_cnt_d  = bit_idx;

    // Transmit: zeros shift in behind the word, so dacdat idles low after the
    // last data bit without extra bookkeeping.
    if (slot_start) begin
      if (LjMode) begin
        dacdat_d = tx_word[SAMPLE_W-1];
        tx_sr_d  = {tx_word[SAMPLE_W-2:0], 1'b0};
      end else begin
        dacdat_d = 1'b0;
        tx_sr_d  = tx_word;
      end
    end else if (b_fall && state_q != StAlign && bit_cnt_q != 5'd0) begin
      dacdat_d = tx_sr_q[SAMPLE_W-1];
      tx_sr_d  = {tx_sr_q[SAMPLE_W-2:0], 1'b0};
    end

    // Receive.
    if (b_rise && state_d != StAlign) begin
      rx_data = (LjMode || bit_idx != 5'd0) && ({1'b0, bit_idx} < RxEnd);
      if (rx_data) begin
        if (state_d == StLeft) rx_l_d = {rx_l_d[SAMPLE_W-2:0], adc_bit_q};
        else                   rx_r_d = {rx_r_d[SAMPLE_W-2:0], adc_bit_q};
      end
      bit_cnt_d   = (bit_idx == 5'd31) ? bit_idx : bit_idx + 5'd1;
      frame_cnt_d = (frame_cnt_d == 8'hFF) ? frame_cnt_d : frame_cnt_d + 8'd1;
    end

    if (state_d == StAlign) begin
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      tx_sr_d     = '0;
      dacdat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StAlign;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      dac_r_q     <= '0;
      tx_sr_q     <= '0;
      dacdat_q    <= 1'b0;
      adc_data_q  <= '0;
      adc_wr_q    <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      dac_r_q     <= dac_r_d;
      tx_sr_q     <= tx_sr_d;
      dacdat_q    <= dacdat_d;
      adc_data_q  <= adc_data_d;
      adc_wr_q    <= adc_wr_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dacdat       = dacdat_q;
  assign adc_data_out = adc_data_q;
  assign adc_wr       = adc_wr_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_slave_if.sv
// Directed bench for i2s_slave_if: a codec model drives b_clk/lr_clk/adcdat
// (64 b_clk per frame unless shortened) and decodes dacdat on b_clk rising edges.
`timescale 1ns/1ps
module tb_i2s_slave_if;

`ifdef I2S_SLAVE_LJ_EN
  localparam int DLY = 0;
`else
  localparam int DLY = 1;
`endif
  localparam int HALF = 80;

  logic        clk, reset, b_clk, lr_clk, adcdat, dacdat;
  logic [31:0] dac_data_in, adc_data_out;
  logic        dac_fifo_empty, dac_rd, adc_fifo_full, adc_wr, underrun, overrun;

  int          n_pass, n_total, wr_cnt, rd_cnt, stray;
  logic [31:0] last_adc, dac_cap;

  i2s_slave_if dut (
    .clk            (clk),
    .reset          (reset),
    .b_clk          (b_clk),
    .lr_clk         (lr_clk),
    .adcdat         (adcdat),
    .dacdat         (dacdat),
    .dac_data_in    (dac_data_in),
    .dac_fifo_empty (dac_fifo_empty),
    .dac_rd         (dac_rd),
    .adc_data_out   (adc_data_out),
    .adc_fifo_full  (adc_fifo_full),
    .adc_wr         (adc_wr),
    .underrun       (underrun),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_cnt   = 0;
    rd_cnt   = 0;
    last_adc = '0;
  end

  always @(negedge clk) begin
    if (adc_wr) begin
      wr_cnt   = wr_cnt + 1;
      last_adc = adc_data_out;
    end
    if (dac_rd) rd_cnt = rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Steps first..last of a frame with hb b_clk periods per slot.
  task automatic run_frame(input logic [15:0] lw, input logic [15:0] rw, input int hb,
                           input int first, input int last);
    for (int s = first; s <= last; s++) begin
      int slot, j;
      slot   = s / hb;
      j      = (s % hb) - DLY;
      b_clk  = 1'b0;
      lr_clk = (slot != 0);
      adcdat = 1'b0;
      if (j >= 0 && j < 16) adcdat = (slot != 0) ? rw[15-j] : lw[15-j];
      #(HALF);
      b_clk = 1'b1;
      if (j >= 0 && j < 16) begin
        if (slot == 0) dac_cap[31-j] = dacdat;
        else           dac_cap[15-j] = dacdat;
      end else if (dacdat !== 1'b0) begin
        stray = stray + 1;
      end
      #(HALF);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; stray = 0; dac_cap = '0;
    reset = 1'b0; b_clk = 1'b1; lr_clk = 1'b1; adcdat = 1'b0;
    dac_data_in = 32'h8001FFFE; dac_fifo_empty = 1'b0; adc_fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_dacdat", 64'(dacdat), 64'd0);
    check("rst_dac_rd", 64'(dac_rd), 64'd0);
    check("rst_adc_wr", 64'(adc_wr), 64'd0);
    check("rst_adc_data", 64'(adc_data_out), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // F1: first aligned frame.
    dac_cap = '0;
    run_frame(16'hA5C3, 16'h1234, 32, 0, 63);
    check("f1_dac_word", 64'(dac_cap), 64'h8001FFFE);
    check("f1_rd_cnt", 64'(rd_cnt), 64'd1);
    check("f1_wr_cnt", 64'(wr_cnt), 64'd0);

    // F2: DAC FIFO empty.
    dac_fifo_empty = 1'b1;
    dac_cap = '1;
    run_frame(16'h5A3C, 16'hEDCB, 32, 0, 63);
    check("f2_wr_cnt", 64'(wr_cnt), 64'd1);
    check("f2_adc_word", 64'(last_adc), 64'hA5C31234);
    check("f2_dac_zero", 64'(dac_cap), 64'd0);
    check("f2_rd_cnt", 64'(rd_cnt), 64'd1);
    check("f2_underrun", 64'(underrun), 64'd1);

    // F3: ADC FIFO full at the edge ending F2.
    dac_fifo_empty = 1'b0;
    dac_data_in = 32'h12345678;
    adc_fifo_full = 1'b1;
    dac_cap = '0;
    run_frame(16'h0F0F, 16'hF0F0, 32, 0, 63);
    check("f3_wr_cnt", 64'(wr_cnt), 64'd1);
    check("f3_adc_data", 64'(adc_data_out), 64'h5A3CEDCB);
    check("f3_overrun", 64'(overrun), 64'd1);
    check("f3_underrun_held", 64'(underrun), 64'd1);
    check("f3_dac_word", 64'(dac_cap), 64'h12345678);

    // F4: full cleared, F3 written at its end.
    adc_fifo_full = 1'b0;
    run_frame(16'h1357, 16'h2468, 32, 0, 63);
    check("f4_wr_cnt", 64'(wr_cnt), 64'd2);
    check("f4_adc_word", 64'(last_adc), 64'h0F0FF0F0);
    check("f4_overrun_held", 64'(overrun), 64'd1);

    // F5: reset pulsed after left slot bit 7.
    run_frame(16'hABCD, 16'hEF01, 32, 0, 7);
    check("f5_wr_cnt", 64'(wr_cnt), 64'd3);
    check("f5_adc_word", 64'(last_adc), 64'h13572468);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_adc_data", 64'(adc_data_out), 64'd0);
    check("mid_rst_dacdat", 64'(dacdat), 64'd0);
    check("mid_rst_underrun", 64'(underrun), 64'd0);
    check("mid_rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(16'hABCD, 16'hEF01, 32, 8, 63);

    // F6: realigned frame; partial F5 must not be written.
    dac_cap = '0;
    run_frame(16'hCAFE, 16'hBEEF, 32, 0, 63);
    check("f6_wr_cnt", 64'(wr_cnt), 64'd3);
    check("f6_rd_cnt", 64'(rd_cnt), 64'd5);
    check("f6_dac_word", 64'(dac_cap), 64'h12345678);

    run_frame(16'h0001, 16'h8000, 32, 0, 63);
    check("f7_wr_cnt", 64'(wr_cnt), 64'd4);
    check("f7_adc_word", 64'(last_adc), 64'hCAFEBEEF);

    // F8: short frame (24 b_clk rises).
    run_frame(16'h7777, 16'h6666, 12, 0, 23);
    check("f8_wr_cnt", 64'(wr_cnt), 64'd5);
    check("f8_left_lsb", 64'(last_adc[31:16]), 64'h0001);
    check("f8_adc_word", 64'(last_adc), 64'h00018000);

    run_frame(16'h1111, 16'h2222, 32, 0, 63);
    run_frame(16'h3333, 16'h4444, 32, 0, 63);
    check("f10_wr_cnt", 64'(wr_cnt), 64'd5);
    run_frame(16'h5555, 16'h6666, 32, 0, 1);
    check("f11_wr_cnt", 64'(wr_cnt), 64'd6);
    check("f11_adc_word", 64'(last_adc), 64'h33334444);
    check("end_overrun", 64'(overrun), 64'd0);
    check("end_underrun", 64'(underrun), 64'd0);
    check("dacdat_outside_window", 64'(stray), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2s_slave_if.md
I2S_SLAVE_IF -- requirements
Module: i2s_slave_if

Interface
REQ-001 Parameter SAMPLE_W, default 16, bits per channel sample (8..24).
REQ-002 Parameter FRAME_MIN, default 32, minimum b_clk periods per LR frame accepted as valid.
REQ-003 clk  input  1  system clock, >= 8x b_clk frequency; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 b_clk  input  1  bit clock driven by codec in master mode; asynchronous to clk.
REQ-006 lr_clk  input  1  LR clock from codec; low = left, high = right; asynchronous.
REQ-007 adcdat  input  1  serial ADC data from codec.
REQ-008 dacdat  output  1  serial DAC data to codec.
REQ-009 dac_data_in  input  2*SAMPLE_W  {left,right} DAC sample from DAC FIFO.
REQ-010 dac_fifo_empty  input  1  DAC FIFO has no data.
REQ-011 dac_rd  output  1  one-cycle pop strobe to DAC FIFO.
REQ-012 adc_data_out  output  2*SAMPLE_W  {left,right} captured ADC sample.
REQ-013 adc_fifo_full  input  1  ADC FIFO cannot accept data.
REQ-014 adc_wr  output  1  one-cycle push strobe to ADC FIFO.
REQ-015 underrun, overrun  output  1 each  sticky error flags, cleared only by reset.

Function
REQ-016 b_clk, lr_clk, adcdat each pass a 2-flop synchronizer; edges detected on synchronized copies; edge pulses lag pins by 3 clk.
REQ-017 States: ALIGN, LEFT, RIGHT; reset enters ALIGN; ALIGN->LEFT on first lr_clk falling edge; LEFT->RIGHT on lr_clk rising edge; RIGHT->LEFT on lr_clk falling edge.
REQ-018 In ALIGN: dacdat = 0, no dac_rd, no adc_wr, bit counter held at 0.
REQ-019 Bit counter (5 bits) clears on every lr_clk edge, increments on each b_clk rising edge, saturates at 31.
REQ-020 I2S timing: first b_clk rising edge after an lr_clk edge carries no data; MSB sampled on second; bits 1..SAMPLE_W after the slot start are data; later bits ignored on receive.
REQ-021 adcdat sampled on b_clk rising edge, shifted MSB-first into the current channel's register.
REQ-022 dacdat changes one clk after detected b_clk falling edge; MSB driven during slot bit 1; after SAMPLE_W bits, dacdat = 0 until next lr_clk edge.
REQ-023 dac_rd pulses one cycle on lr_clk falling edge (LEFT entry) when dac_fifo_empty = 0; dac_data_in is registered the same cycle (show-ahead FIFO).
REQ-024 If dac_fifo_empty = 1 at that edge: no dac_rd, frame transmits zeros, underrun set.
REQ-025 adc_wr pulses one cycle on lr_clk falling edge ending a RIGHT slot, with adc_data_out updated that cycle to the completed {left,right}.
REQ-026 If adc_fifo_full = 1 then: no adc_wr, adc_data_out still updates, overrun set.
REQ-027 Frame with fewer than FRAME_MIN b_clk rising edges: no adc_wr, state returns to ALIGN, no flag change.
REQ-028 Simultaneous lr_clk edge and b_clk edge detection: lr_clk edge processed first (counter clear), then b_clk edge counted as slot bit 0.

Reset
REQ-029 Reset asserted: state ALIGN, counters 0, shift registers 0, dacdat 0, dac_rd 0, adc_wr 0, adc_data_out 0, underrun 0, overrun 0.
REQ-030 Reset mid-frame discards the partial frame; after release, realignment waits for the next lr_clk falling edge.

Configuration
REQ-031 Macro I2S_SLAVE_LJ_EN defined: left-justified format, MSB on first b_clk rising edge after an lr_clk edge (data bits 0..SAMPLE_W-1); undefined: standard I2S one-bit delay per REQ-020.

Structure
REQ-032 Shared package holds the state enumeration (ALIGN, LEFT, RIGHT) and the default SAMPLE_W and FRAME_MIN constants.
REQ-033 One sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for b_clk and lr_clk; adcdat uses the synchronizer only.

Verification
REQ-034 Codec model, 64 b_clk per frame, adcdat left=0xA5C3 right=0x1234 -> one adc_wr, adc_data_out = 0xA5C31234.
REQ-035 dac_data_in = 0x8001FFFE, dac_fifo_empty=0 -> one dac_rd at frame start; decoded dacdat left=0x8001, right=0xFFFE, one-bit I2S delay.
REQ-036 dac_fifo_empty=1 for one frame -> dacdat all 0, no dac_rd, underrun=1 and held.
REQ-037 adc_fifo_full=1 at frame end -> no adc_wr, overrun=1, next frame with full=0 writes normally.
REQ-038 Reset pulsed at slot bit 7 of LEFT -> outputs zero, first adc_wr only after one complete frame following next lr_clk falling edge.
REQ-039 I2S_SLAVE_LJ_EN defined, left=0x0001 -> LSB captured at slot bit 15, adc_data_out[31:16] = 0x0001.
